// File: rtl/branch_predictor_if.sv
// Fetch/execute signal bundle between the pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] PCF;
    logic                  branch_predictF;
    logic [DATA_WIDTH-1:0] predict_targetF;
    logic                  branch_validE;
    logic [DATA_WIDTH-1:0] PCE;
    logic                  takenE;
    logic [DATA_WIDTH-1:0] PCTargetE;
    logic                  branch_predictE;
    logic                  mispredictE;
    logic [31:0]           branch_count;
    logic [31:0]           mispredict_count;

    modport master (
        output PCF, branch_validE, PCE, takenE, PCTargetE, branch_predictE,
        input  branch_predictF, predict_targetF, mispredictE,
               branch_count, mispredict_count
    );

    modport slave (
        input  PCF, branch_validE, PCE, takenE, PCTargetE, branch_predictE,
        output branch_predictF, predict_targetF, mispredictE,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BHT with 2-bit saturating counters and target buffer.
// Optional PREDICTOR_STATS_EN adds branch/mispredict event counters.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input logic              clk,
    input logic              rst,
    branch_predictor_if.slave bp
);
    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int          TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    logic                  valid_q  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    ctr_t                  ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]      tag_f, tag_e;
    logic                  hit_f, hit_e;
    ctr_t                  ctr_nxt;

    assign idx_f = bp.PCF[INDEX_BITS+1:2];
    assign tag_f = bp.PCF[DATA_WIDTH-1:INDEX_BITS+2];
    assign idx_e = bp.PCE[INDEX_BITS+1:2];
    assign tag_e = bp.PCE[DATA_WIDTH-1:INDEX_BITS+2];

    // Fetch lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign hit_f              = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign bp.branch_predictF = hit_f && ctr_q[idx_f][1];
    assign bp.predict_targetF = hit_f ? target_q[idx_f] : '0;

    assign hit_e          = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign bp.mispredictE = bp.branch_validE && (bp.takenE != bp.branch_predictE);

    always_comb begin
        ctr_nxt = ctr_q[idx_e];
        if (bp.takenE) begin
            unique case (ctr_q[idx_e])
                SNT:     ctr_nxt = WNT;
                WNT:     ctr_nxt = WT;
                WT:      ctr_nxt = ST;
                default: ctr_nxt = ST;
            endcase
        end else begin
            unique case (ctr_q[idx_e])
                ST:      ctr_nxt = WT;
                WT:      ctr_nxt = WNT;
                WNT:     ctr_nxt = SNT;
                default: ctr_nxt = SNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (bp.branch_validE) begin
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_nxt;
                if (bp.takenE)
                    target_q[idx_e] <= bp.PCTargetE;
            end else if (bp.takenE) begin
                // Allocation evicts whatever aliased entry occupied this index.
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= bp.PCTargetE;
                ctr_q[idx_e]    <= WT;
            end
        end
    end

`ifdef PREDICTOR_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (bp.branch_validE)
                branch_cnt_q <= branch_cnt_q + 32'd1;
            if (bp.mispredictE)
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = mispredict_cnt_q;
`else
    assign bp.branch_count     = '0;
    assign bp.mispredict_count = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 32-bit, 16 entries).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_bc   = 0;
    int   exp_mc   = 0;

    branch_predictor_if #(.DATA_WIDTH(32)) bp ();

    branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pcf,
                        input logic exp_pred, input logic [31:0] exp_tgt);
        @(negedge clk);
        bp.PCF = pcf;
        #1;
        chk({tag, "_pred"}, {31'd0, bp.branch_predictF}, {31'd0, exp_pred});
        chk({tag, "_tgt"}, bp.predict_targetF, exp_tgt);
    endtask

    task automatic upd(input string tag, input logic [31:0] pce, input logic tk,
                       input logic [31:0] tgt, input logic pred);
        @(negedge clk);
        bp.branch_validE   = 1'b1;
        bp.PCE             = pce;
        bp.takenE          = tk;
        bp.PCTargetE       = tgt;
        bp.branch_predictE = pred;
        #1;
        chk({tag, "_mispredictE"}, {31'd0, bp.mispredictE}, {31'd0, (tk != pred)});
        @(posedge clk);
        #1;
        bp.branch_validE = 1'b0;
        exp_bc++;
        if (tk != pred) exp_mc++;
    endtask

    task automatic chk_stats(input string tag);
`ifdef PREDICTOR_STATS_EN
        chk({tag, "_branch_count"}, bp.branch_count, exp_bc);
        chk({tag, "_mispredict_count"}, bp.mispredict_count, exp_mc);
`else
        chk({tag, "_branch_count"}, bp.branch_count, 32'd0);
        chk({tag, "_mispredict_count"}, bp.mispredict_count, 32'd0);
`endif
    endtask

    initial begin
        bp.PCF             = '0;
        bp.branch_validE   = 1'b0;
        bp.PCE             = '0;
        bp.takenE          = 1'b0;
        bp.PCTargetE       = '0;
        bp.branch_predictE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        look("reset_0x100", 32'h100, 1'b0, 32'h0);
        look("reset_0x3fc", 32'h3fc, 1'b0, 32'h0);
        chk_stats("reset");

        // mispredictE gated by branch_validE
        @(negedge clk);
        bp.takenE = 1'b1;
        bp.branch_predictE = 1'b0;
        #1;
        chk("mispredict_gated", {31'd0, bp.mispredictE}, 32'd0);

        // First taken allocates at WT
        upd("alloc", 32'h100, 1'b1, 32'h200, 1'b0);
        look("alloc_wt", 32'h100, 1'b1, 32'h200);
        look("low_bits_ignored", 32'h103, 1'b1, 32'h200);
        chk_stats("after_alloc");

        // Not-taken walks down; target kept
        upd("nt1", 32'h100, 1'b0, 32'h999, 1'b1);
        look("wnt", 32'h100, 1'b0, 32'h200);
        upd("nt2", 32'h100, 1'b0, 32'h999, 1'b0);
        look("snt", 32'h100, 1'b0, 32'h200);
        upd("nt3", 32'h100, 1'b0, 32'h999, 1'b0);
        look("snt_sat", 32'h100, 1'b0, 32'h200);

        // Two takens needed from SNT; hit-taken refreshes target
        upd("t1", 32'h100, 1'b1, 32'h220, 1'b0);
        look("wnt_up", 32'h100, 1'b0, 32'h220);
        upd("t2", 32'h100, 1'b1, 32'h240, 1'b0);
        look("wt_up", 32'h100, 1'b1, 32'h240);

        // Saturate at ST, then one not-taken still predicts taken
        upd("t3", 32'h100, 1'b1, 32'h240, 1'b1);
        upd("t4", 32'h100, 1'b1, 32'h240, 1'b1);
        upd("nt4", 32'h100, 1'b0, 32'h0, 1'b1);
        look("st_sat_wt", 32'h100, 1'b1, 32'h240);
        upd("nt5", 32'h100, 1'b0, 32'h0, 1'b1);
        look("st_sat_wnt", 32'h100, 1'b0, 32'h240);
        chk_stats("after_training");

        // Alias on index 0 evicts 0x100
        upd("alias", 32'h140, 1'b1, 32'h300, 1'b0);
        look("alias_evicted", 32'h100, 1'b0, 32'h0);
        look("alias_new", 32'h140, 1'b1, 32'h300);

        // Miss with not-taken leaves the table alone
        upd("miss_nt", 32'h180, 1'b0, 32'h400, 1'b0);
        look("miss_nt_keep", 32'h140, 1'b1, 32'h300);
        look("miss_nt_noalloc", 32'h180, 1'b0, 32'h0);

        // Same-cycle lookup/update: old contents this cycle, new ones next
        @(negedge clk);
        bp.PCF             = 32'h100;
        bp.branch_validE   = 1'b1;
        bp.PCE             = 32'h100;
        bp.takenE          = 1'b1;
        bp.PCTargetE       = 32'h500;
        bp.branch_predictE = 1'b0;
        #1;
        chk("same_cycle_pred", {31'd0, bp.branch_predictF}, 32'd0);
        chk("same_cycle_tgt", bp.predict_targetF, 32'h0);
        @(posedge clk);
        #1;
        bp.branch_validE = 1'b0;
        exp_bc++;
        exp_mc++;
        chk("next_cycle_pred", {31'd0, bp.branch_predictF}, 32'd1);
        chk("next_cycle_tgt", bp.predict_targetF, 32'h500);
        chk_stats("before_rst");

        // Reset mid-stream drops a concurrent update
        @(negedge clk);
        rst                = 1'b1;
        bp.branch_validE   = 1'b1;
        bp.PCE             = 32'h108;
        bp.takenE          = 1'b1;
        bp.PCTargetE       = 32'h600;
        bp.branch_predictE = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bp.branch_validE = 1'b0;
        exp_bc = 0;
        exp_mc = 0;
        look("rst_drop_upd", 32'h108, 1'b0, 32'h0);
        look("rst_clears", 32'h100, 1'b0, 32'h0);
        chk_stats("after_rst");

        // Counting resumes from zero after reset
        upd("post_rst", 32'h10c, 1'b1, 32'h700, 1'b0);
        look("post_rst_alloc", 32'h10c, 1'b1, 32'h700);
        chk_stats("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
